// File: rtl/tetris_pkg.sv
// Shared game constants, piece codes and the spawn FSM state encoding.
package tetris_pkg;

  localparam logic [7:0]  NEXT_PIECE_BASE_ADDR = 8'd240;
  localparam int unsigned FIELD_WIDTH          = 10;
  localparam int unsigned SPAWN_COL            = 4;

  // Grid cells hold code = piece type + 1; code 0 is air.
  localparam logic [7:0]  CODE_AIR             = 8'd0;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    CHECK,
    WRITE,
    DONE
  } state_t;

  function automatic logic [7:0] piece_code(input logic [2:0] piece_type);
    return {5'd0, piece_type} + 8'd1;
  endfunction

  function automatic logic [2:0] code_to_type(input logic [7:0] code);
    return code[2:0] - 3'd1;
  endfunction

endpackage

// File: rtl/preview_cell_map.sv
// Maps a preview-box index (4 rows x 3 columns) to its spawn address in the play field.
module preview_cell_map #(
  parameter int unsigned FIELD_WIDTH = tetris_pkg::FIELD_WIDTH,
  parameter int unsigned SPAWN_COL   = tetris_pkg::SPAWN_COL
) (
  input  logic [3:0] idx,
  output logic [7:0] field_addr
);
  import tetris_pkg::*;

  logic [3:0] row;
  logic [3:0] col;

  // Preview row k/3 becomes field row k/3; preview column k%3 is offset from SPAWN_COL.
  always_comb begin
    row        = idx / 4'd3;
    col        = idx % 4'd3;
    field_addr = 8'(row) * 8'(FIELD_WIDTH) + 8'(SPAWN_COL) + 8'(col);
  end

endmodule

// File: rtl/next_piece_loader.sv
// Reads the next-piece preview box, validates it, checks the spawn area for
// collision and either writes the piece into the field or reports game over.
module next_piece_loader #(
  parameter logic [7:0]  NEXT_PIECE_BASE_ADDR = tetris_pkg::NEXT_PIECE_BASE_ADDR,
  parameter int unsigned FIELD_WIDTH          = tetris_pkg::FIELD_WIDTH,
  parameter int unsigned SPAWN_COL            = tetris_pkg::SPAWN_COL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic       game_over,
  output logic       bad_piece,
  output logic [2:0] piece_type,
  output logic [7:0] cell0_addr,
  output logic [7:0] cell1_addr,
  output logic [7:0] cell2_addr,
  output logic [7:0] cell3_addr
);
  import tetris_pkg::*;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] occ_q, occ_d;
  logic [7:0] code_q, code_d;
  logic       bad_q, bad_d;
  logic [7:0] cell_q [4];
  logic [7:0] cell_d [4];
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       game_over_q, game_over_d;
  logic       bad_piece_q, bad_piece_d;
  logic [2:0] piece_type_q, piece_type_d;
  logic [7:0] map_addr;

  // Read data lags the address by one cycle, so the datum in hand belongs to index cnt-1.
  preview_cell_map #(
    .FIELD_WIDTH (FIELD_WIDTH),
    .SPAWN_COL   (SPAWN_COL)
  ) u_map (
    .idx        (cnt_q - 4'd1),
    .field_addr (map_addr)
  );

  // Next-state and registered-output computation for the spawn sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    occ_d        = occ_q;
    code_d       = code_q;
    bad_d        = bad_q;
    cell_d       = cell_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    game_over_d  = game_over_q;
    bad_piece_d  = bad_piece_q;
    piece_type_d = piece_type_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          cnt_d        = '0;
          occ_d        = '0;
          code_d       = CODE_AIR;
          bad_d        = 1'b0;
          game_over_d  = 1'b0;
          bad_piece_d  = 1'b0;
          piece_type_d = '0;
          mem_addr_d   = NEXT_PIECE_BASE_ADDR;
        end
      end

      SCAN: begin
        if (cnt_q != 4'd0 && mem_rdata != CODE_AIR) begin
          if (occ_q == 3'd0) begin
            code_d = mem_rdata;
          end else if (mem_rdata != code_q) begin
            bad_d = 1'b1;
          end
          if (occ_q < 3'd4) begin
            cell_d[occ_q[1:0]] = map_addr;
            occ_d              = occ_q + 3'd1;
          end else begin
            bad_d = 1'b1;
            occ_d = 3'd5;
          end
        end
        // Decision uses the _d values so the datum captured in the drain cycle counts.
        if (cnt_q == 4'd12) begin
          if (bad_d || occ_d != 3'd4) begin
            state_d     = DONE;
            done_d      = 1'b1;
            bad_piece_d = 1'b1;
          end else begin
            state_d      = CHECK;
            cnt_d        = '0;
            mem_addr_d   = cell_d[0];
            piece_type_d = code_to_type(code_d);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q < 4'd11) begin
            mem_addr_d = NEXT_PIECE_BASE_ADDR + {4'd0, cnt_q} + 8'd1;
          end
        end
      end

      CHECK: begin
        if (cnt_q != 4'd0 && mem_rdata != CODE_AIR) begin
          game_over_d = 1'b1;
        end
        if (cnt_q == 4'd4) begin
          if (game_over_d) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = WRITE;
            cnt_d       = '0;
            mem_we_d    = 1'b1;
            mem_addr_d  = cell_q[0];
            mem_wdata_d = code_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q < 4'd3) begin
            mem_addr_d = cell_q[cnt_q[1:0] + 2'd1];
          end
        end
      end

      WRITE: begin
        if (cnt_q == 4'd3) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d       = cnt_q + 4'd1;
          mem_we_d    = 1'b1;
          mem_addr_d  = cell_q[cnt_q[1:0] + 2'd1];
          mem_wdata_d = code_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; synchronous reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      occ_q        <= '0;
      code_q       <= '0;
      bad_q        <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cell_q[i] <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      game_over_q  <= 1'b0;
      bad_piece_q  <= 1'b0;
      piece_type_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      occ_q        <= occ_d;
      code_q       <= code_d;
      bad_q        <= bad_d;
      cell_q       <= cell_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      game_over_q  <= game_over_d;
      bad_piece_q  <= bad_piece_d;
      piece_type_q <= piece_type_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign game_over  = game_over_q;
  assign bad_piece  = bad_piece_q;
  assign piece_type = piece_type_q;
  assign cell0_addr = cell_q[0];
  assign cell1_addr = cell_q[1];
  assign cell2_addr = cell_q[2];
  assign cell3_addr = cell_q[3];

endmodule

// File: doc/next_piece_loader.md
# next_piece_loader

Spawns the previewed piece into the play field. On `start` it reads the 12-cell next-piece preview box from grid memory, extracts the piece code and its four occupied cells, and maps them to spawn addresses in the play field. It then checks those addresses for collision. If the field is clear, it writes the piece in; if not, it reports game over. It sits between the game controller and grid memory, on the consuming side of the preview box that the piece placer fills.

## Interface
Parameters:
- `NEXT_PIECE_BASE_ADDR`, 8'd240: first address of the preview box. The box is 4 rows x 3 columns; cell k lives at base+k, row k/3, column k%3.
- `FIELD_WIDTH`, 10: play-field columns. Field address = row*FIELD_WIDTH + col, range 0..239.
- `SPAWN_COL`, 4: field column that preview column 0 maps to. Preview rows map to field rows 0..3.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request a spawn; sampled only in IDLE
- `mem_rdata`  in  8  grid memory read data, valid one cycle after `mem_addr` is presented
- `mem_we`  out  1  grid memory write enable
- `mem_addr`  out  8  grid memory address
- `mem_wdata`  out  8  grid memory write data
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of every accepted request
- `game_over`  out  1  spawn cells occupied; valid from `done`, held until next accepted `start`
- `bad_piece`  out  1  preview malformed; valid from `done`, held until next accepted `start`
- `piece_type`  out  3  preview code minus 1 (I=0 … L=6); valid with `done`
- `cell0_addr`..`cell3_addr`  out  8 each  field addresses of the spawned cells, in ascending preview-index order

## Operation
- All outputs are registered. Reset value of every output is 0. The reset state is IDLE.
- IDLE: `start`=1 clears the status outputs and the cell count, then moves to SCAN.
- SCAN: issues reads of base+0..base+11 on consecutive cycles, then spends one drain cycle capturing the last `mem_rdata`.
  - Each nonzero datum is appended to the occupied-cell list as its mapped field address.
  - The first nonzero value latches the code.
  - A nonzero value that differs from the latched code, or a 5th occupied cell, sets the internal bad flag.
- After SCAN:
  - If bad is set, or the count is not 4, go to DONE with `bad_piece`=1.
  - Otherwise go to CHECK.
- CHECK: reads the 4 cell addresses on consecutive cycles, plus one drain cycle. Any nonzero read sets game over.
- After CHECK:
  - If game over is set, go to DONE with `game_over`=1 and perform no writes.
  - Otherwise go to WRITE.
- WRITE: 4 cycles with `mem_we`=1, `mem_addr`=cellN_addr, `mem_wdata`=code, in order N=0..3. The preview box is never modified.
- DONE: `done`=1 for one cycle, `mem_we`=0, then return to IDLE.
- `mem_we` is 0 outside WRITE. `mem_addr` and `mem_wdata` hold their last values when idle.
- `start` while `busy` is ignored.
- `rst` mid-operation: IDLE on the next edge, `mem_we`=0 on that edge, no `done` pulse, and any partial writes are left as they are.
- The cell counter is 3 bits and saturates at 5. Field-address arithmetic is 8-bit; for legal parameters the maximum is 3*FIELD_WIDTH+SPAWN_COL+2 (36 with defaults), so it never overflows.

## Timing
- `start` sampled at edge 0. SCAN occupies cycles 1–13, with addresses base+0..11 on cycles 1–12.
- Success path: CHECK occupies cycles 14–18, WRITE occupies cycles 19–22, `done` is high in cycle 23.
- Game-over path: `done` is high in cycle 19.
- Bad-piece path: `done` is high in cycle 14.
- Back-to-back: `start` held high is re-accepted in the cycle after `done`.

## Structure
- Shared `tetris_pkg` holds:
  - `NEXT_PIECE_BASE_ADDR`, `FIELD_WIDTH`, `SPAWN_COL`
  - piece codes I..L = 0..6 and the "code = type+1, 0 = air" convention
  - the FSM state enum (IDLE, SCAN, CHECK, WRITE, DONE)
- One sub-module, `preview_cell_map`: combinational mapping from preview index (4 bits) to field address (8 bits), (k/3)*FIELD_WIDTH + SPAWN_COL + k%3.

## Test plan
- I piece: preview cells 0, 3, 6, 9 hold 1, the rest 0, field empty. Required: writes of 1 to 4, 14, 24, 34; `piece_type`=0; `done` in cycle 23; `game_over`=`bad_piece`=0.
- T piece: cells 4, 6, 7, 10 hold 3. Required: writes of 3 to 15, 24, 25, 35 in that order; `piece_type`=2.
- O piece: cells 6, 7, 9, 10 hold 2, and field[25]=5. Required: `game_over`=1, `done` in cycle 19, `mem_we` never asserted.
- Bad preview cases, each giving `bad_piece`=1 with `done` in cycle 14 and no writes:
  - all-zero preview;
  - five cells holding 4;
  - cells holding mixed 2 and 3.
- `rst` asserted in cycle 20 of a success run. Required: all outputs 0 next cycle, no `done`. A new `start` then completes normally.
- `start` pulsed during SCAN. Required: ignored, exactly one `done`.
